// File: rtl/pool_upsampler_if.sv
// Pixel stream bundle for the pool upsampler: pooled input side and full-resolution output side.
interface pool_upsampler_if #(
  parameter int DW = 16
);
  logic [DW-1:0] pixel_in;
  logic          i_data_valid;
  logic          o_ready;
  logic [DW-1:0] pixel_out;
  logic          o_data_valid;
  logic          o_frame_done;

  modport master (
    output pixel_in, i_data_valid,
    input  o_ready, pixel_out, o_data_valid, o_frame_done
  );

  modport slave (
    input  pixel_in, i_data_valid,
    output o_ready, pixel_out, o_data_valid, o_frame_done
  );
endinterface

// File: rtl/pool_upsampler.sv
// Nearest-neighbour upsampler: captures one pooled row, then replays it P times
// with every pixel repeated P times, rebuilding the full-resolution raster.
module pool_upsampler #(
  parameter int W_IN = 14,
  parameter int H_IN = 14,
  parameter int P    = 2,
  parameter int DW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  pool_upsampler_if.slave  bus
);
  localparam int WC = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int PC = (P    > 1) ? $clog2(P)    : 1;
  localparam int HC = (H_IN > 1) ? $clog2(H_IN) : 1;

  localparam logic [WC-1:0] COL_LAST = WC'(W_IN - 1);
  localparam logic [PC-1:0] REP_LAST = PC'(P - 1);
  localparam logic [HC-1:0] ROW_LAST = HC'(H_IN - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t          state_q, state_d;
  logic [WC-1:0]   wr_col_q, wr_col_d;
  logic [WC-1:0]   rd_col_q, rd_col_d;
  logic [PC-1:0]   rep_col_q, rep_col_d;
  logic [PC-1:0]   rep_row_q, rep_row_d;
  logic [HC-1:0]   row_cnt_q, row_cnt_d;
  logic [DW-1:0]   pixel_out_q, pixel_out_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_done_q, frame_done_d;

  logic [DW-1:0]   row_mem [W_IN];
  logic            accept;
  logic            col_last;
  logic            pix_last;

  assign accept   = bus.i_data_valid && (state_q == FILL);
  assign col_last = (rep_col_q == REP_LAST);
  assign pix_last = col_last && (rd_col_q == COL_LAST);

  // Row buffer is deliberately left out of reset; only accepted pixels are ever replayed.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_mem[wr_col_q] <= bus.pixel_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_col_d     = wr_col_q;
    rd_col_d     = rd_col_q;
    rep_col_d    = rep_col_q;
    rep_row_d    = rep_row_q;
    row_cnt_d    = row_cnt_q;
    pixel_out_d  = pixel_out_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (wr_col_q == COL_LAST) begin
            wr_col_d = '0;
            state_d  = EMIT;
          end else begin
            wr_col_d = wr_col_q + 1'b1;
          end
        end
      end

      EMIT: begin
        pixel_out_d  = row_mem[rd_col_q];
        data_valid_d = 1'b1;
        rep_col_d    = col_last ? '0 : rep_col_q + 1'b1;
        if (col_last) begin
          rd_col_d = (rd_col_q == COL_LAST) ? '0 : rd_col_q + 1'b1;
        end
        // Final replay of the final pixel: hand control back to capture on this same edge.
        if (pix_last) begin
          if (rep_row_q == REP_LAST) begin
            rep_row_d = '0;
            state_d   = FILL;
            if (row_cnt_q == ROW_LAST) begin
              row_cnt_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end else begin
            rep_row_d = rep_row_q + 1'b1;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      wr_col_q     <= '0;
      rd_col_q     <= '0;
      rep_col_q    <= '0;
      rep_row_q    <= '0;
      row_cnt_q    <= '0;
      pixel_out_q  <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      rd_col_q     <= rd_col_d;
      rep_col_q    <= rep_col_d;
      rep_row_q    <= rep_row_d;
      row_cnt_q    <= row_cnt_d;
      pixel_out_q  <= pixel_out_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.o_ready      = (state_q == FILL);
  assign bus.pixel_out    = pixel_out_q;
  assign bus.o_data_valid = data_valid_q;
  assign bus.o_frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_upsampler.sv
// Bench for pool_upsampler: a small 4x2 (P=2) instance checked cycle by cycle against a
// row-replay model, plus a default-size instance checked frame-wide as out(r,c) = in(r/2,c/2).
module tb_pool_upsampler;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int SP = 2;
  localparam int DWT = 16;

  logic clk;
  logic reset;

  pool_upsampler_if #(.DW(DWT)) s_if ();
  pool_upsampler_if #(.DW(DWT)) d_if ();

  pool_upsampler #(.W_IN(SW), .H_IN(SH), .P(SP), .DW(DWT)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if)
  );

  pool_upsampler dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (d_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Small-instance reference: a row is captured, then W*P*P replay slots follow;
  // slot k shows input column (k mod W*P)/P.
  int               m_left;
  int               m_rows;
  logic [DWT-1:0]   m_fill[$];
  logic [DWT-1:0]   m_row[SW];
  logic [DWT-1:0]   m_pix;
  logic [DWT-1:0]   outs[$];
  int               fd_idx[$];

  task automatic model_reset();
    m_left = 0;
    m_rows = 0;
    m_fill.delete();
    m_pix  = '0;
    outs.delete();
    fd_idx.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_s_valid", 32'(s_if.o_data_valid), 32'd0);
    check("rst_s_ready", 32'(s_if.o_ready), 32'd1);
    check("rst_s_fdone", 32'(s_if.o_frame_done), 32'd0);
    check("rst_s_pixel", 32'(s_if.pixel_out), 32'd0);
    check("rst_d_valid", 32'(d_if.o_data_valid), 32'd0);
    check("rst_d_ready", 32'(d_if.o_ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step_s(input logic v, input logic [DWT-1:0] d);
    logic exp_v;
    logic exp_fd;
    int   k;
    s_if.i_data_valid = v;
    s_if.pixel_in     = d;
    check("s_ready", 32'(s_if.o_ready), 32'(m_left == 0));
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (m_left > 0) begin
      k      = SW * SP * SP - m_left;
      m_pix  = m_row[(k % (SW * SP)) / SP];
      exp_v  = 1'b1;
      m_left--;
      if (m_left == 0) begin
        if (m_rows == SH - 1) begin
          exp_fd = 1'b1;
          m_rows = 0;
        end else begin
          m_rows++;
        end
      end
    end else if (v) begin
      m_fill.push_back(d);
      if (m_fill.size() == SW) begin
        for (int i = 0; i < SW; i++) m_row[i] = m_fill[i];
        m_fill.delete();
        m_left = SW * SP * SP;
        $display("[TB] small row captured: %0d %0d %0d %0d", m_row[0], m_row[1], m_row[2], m_row[3]);
      end
    end
    @(posedge clk);
    #1;
    check("s_valid", 32'(s_if.o_data_valid), 32'(exp_v));
    check("s_fdone", 32'(s_if.o_frame_done), 32'(exp_fd));
    check("s_pixel", 32'(s_if.pixel_out), 32'(m_pix));
    if (s_if.o_data_valid) begin
      outs.push_back(s_if.pixel_out);
      if (s_if.o_frame_done) fd_idx.push_back(outs.size());
    end
  endtask

  task automatic feed_row(input logic [DWT-1:0] a, input logic [DWT-1:0] b,
                          input logic [DWT-1:0] c, input logic [DWT-1:0] e);
    step_s(1'b1, a);
    step_s(1'b1, b);
    step_s(1'b1, c);
    step_s(1'b1, e);
  endtask

  task automatic idle_s(input int n);
    for (int i = 0; i < n; i++) step_s(1'b0, 16'hBEEF);
  endtask

  initial begin
    logic [DWT-1:0] seq_a[$];
    logic [DWT-1:0] seq_g[$];
    logic [DWT-1:0] d_outs[$];
    int             d_fd[$];
    int             fed;
    int             busy;
    int             cyc;
    int             saw99;
    logic           v;

    reset = 1'b1;
    s_if.i_data_valid = 1'b0;
    s_if.pixel_in     = '0;
    d_if.i_data_valid = 1'b0;
    d_if.pixel_in     = '0;
    #1;
    do_reset();

    // Basic replay of one row and the two-row frame boundary.
    seq_a = '{1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4};
    feed_row(1, 2, 3, 4);
    idle_s(18);
    check("seqA_len", 32'(outs.size()), 32'd16);
    for (int i = 0; i < 16 && i < outs.size(); i++) check("seqA_pix", 32'(outs[i]), 32'(seq_a[i]));
    check("seqA_nofd", 32'(fd_idx.size()), 32'd0);
    feed_row(9, 10, 11, 12);
    idle_s(18);
    check("frame_len", 32'(outs.size()), 32'd32);
    check("frame_fd_cnt", 32'(fd_idx.size()), 32'd1);
    if (fd_idx.size() > 0) check("frame_fd_pos", 32'(fd_idx[0]), 32'd32);
    if (outs.size() >= 32) check("frame_last", 32'(outs[31]), 32'd12);
    feed_row(5, 6, 7, 8);
    idle_s(18);
    check("row3_no_fd", 32'(fd_idx.size()), 32'd1);

    // Input gaps must not change the output.
    do_reset();
    seq_g = '{5,5,6,6,7,7,8,8,5,5,6,6,7,7,8,8};
    step_s(1'b1, 5); step_s(1'b0, 0); step_s(1'b0, 0); step_s(1'b1, 6);
    step_s(1'b1, 7); step_s(1'b0, 0); step_s(1'b1, 8);
    idle_s(18);
    check("gap_len", 32'(outs.size()), 32'd16);
    for (int i = 0; i < 16 && i < outs.size(); i++) check("gap_pix", 32'(outs[i]), 32'(seq_g[i]));

    // Pixels offered during replay are dropped; the next row starts right after ready rises.
    outs.delete();
    feed_row(40, 41, 42, 43);
    for (int i = 0; i < SW * SP * SP; i++) step_s(1'b1, 99);
    feed_row(30, 31, 32, 33);
    idle_s(18);
    saw99 = 0;
    foreach (outs[i]) if (outs[i] == 99) saw99++;
    check("drop_99", 32'(saw99), 32'd0);
    check("drop_len", 32'(outs.size()), 32'd32);
    if (outs.size() >= 19) begin
      check("drop_next0", 32'(outs[16]), 32'd30);
      check("drop_next2", 32'(outs[18]), 32'd31);
    end

    // Reset in the middle of a replay.
    do_reset();
    feed_row(1, 2, 3, 4);
    cyc = 0;
    while (outs.size() < 6 && cyc < 40) begin
      step_s(1'b0, 0);
      cyc++;
    end
    check("mid_six_outs", 32'(outs.size()), 32'd6);
    do_reset();
    feed_row(20, 21, 22, 23);
    idle_s(4);
    if (outs.size() >= 3) begin
      check("fresh_0", 32'(outs[0]), 32'd20);
      check("fresh_1", 32'(outs[1]), 32'd20);
      check("fresh_2", 32'(outs[2]), 32'd21);
    end else begin
      check("fresh_len", 32'(outs.size()), 32'd3);
    end
    idle_s(14);

    // Random valid/data traffic against the model.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      step_s(v, 16'($urandom));
    end
    idle_s(18);

    // Default-size instance: ramp 0..195 with random gaps and junk offered while busy.
    s_if.i_data_valid = 1'b0;
    fed  = 0;
    busy = 0;
    cyc  = 0;
    while (d_outs.size() < 784 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0) && (fed < 196);
      d_if.i_data_valid = v;
      d_if.pixel_in     = (busy == 0) ? 16'(fed) : 16'hFFFF;
      if (busy > 0) begin
        busy--;
      end else if (v) begin
        fed++;
        if (fed % 14 == 0) begin
          busy = 56;
          $display("[TB] default row %0d fed", fed / 14 - 1);
        end
      end
      @(posedge clk);
      #1;
      if (d_if.o_data_valid) begin
        d_outs.push_back(d_if.pixel_out);
        if (d_if.o_frame_done) d_fd.push_back(d_outs.size());
      end
      cyc++;
    end
    d_if.i_data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (d_if.o_data_valid) d_outs.push_back(d_if.pixel_out);
      if (d_if.o_frame_done) d_fd.push_back(d_outs.size());
    end
    check("def_count", 32'(d_outs.size()), 32'd784);
    for (int i = 0; i < 784 && i < d_outs.size(); i++) begin
      check("def_pix", 32'(d_outs[i]), 32'(((i / 28) / 2) * 14 + (i % 28) / 2));
    end
    check("def_fd_cnt", 32'(d_fd.size()), 32'd1);
    if (d_fd.size() > 0) check("def_fd_pos", 32'(d_fd[0]), 32'd784);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
